// File: rtl/sram_read_dispatch.sv
// sram_read_dispatch: round-robin arbitration of N_REQ read requesters onto a
// single SRAM read port, with a tag pipeline tracking each read through the
// fixed SRAM latency into per-requester response FIFOs. Credit counters bound
// in-flight plus buffered reads per requester to RSP_DEPTH.
// Optional macro SRAM_RD_REG_EN: register sram_rd_data before the FIFO write
// (adds one tag stage, accept->rsp_valid latency becomes RD_LAT+2).
module sram_read_dispatch #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       sram_rd_en,
    output logic [ADDR_W-1:0]          sram_rd_addr,
    input  logic [DATA_W-1:0]          sram_rd_data,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [N_REQ*DATA_W-1:0]    rsp_data,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic                       busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int AW    = $clog2(RSP_DEPTH);
`ifdef SRAM_RD_REG_EN
    localparam int STG   = RD_LAT + 1;
`else
    localparam int STG   = RD_LAT;
`endif

    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0]  cnt [N_REQ];
    logic [N_REQ-1:0]  elig, grant, pop, push;
    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic              found;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  idx;
    logic [STG-1:0]    tag_vld;
    logic [N_REQ-1:0]  tag_id [STG];
    logic [DATA_W-1:0] wr_data;
    logic [AW:0]       wr_ptr [N_REQ];
    logic [AW:0]       rd_ptr [N_REQ];
    logic [DATA_W-1:0] mem [N_REQ][RSP_DEPTH];

    assign req_ready  = grant;
    assign sram_rd_en = |grant;

    // Per-requester eligibility, address unpacking, FIFO status and pops
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        elig      = '0;
        pop       = '0;
        busy      = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            elig[i]     = req_valid[i] && (cnt[i] < CNT_W'(RSP_DEPTH));
            rsp_valid[i] = (wr_ptr[i] != rd_ptr[i]);
            pop[i]      = rsp_valid[i] & rsp_ready[i];
            if (rsp_valid[i])
                rsp_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i][AW-1:0]];
            busy = busy | (cnt[i] != '0);
        end
    end

    // Round-robin search starting at ptr; no grant while reset is held
    always_comb begin
        grant        = '0;
        ptr_nxt      = ptr;
        sram_rd_addr = '0;
        found        = 1'b0;
        sum          = '0;
        idx          = '0;
        for (int unsigned o = 0; o < N_REQ; o++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(o);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && !reset && elig[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                sram_rd_addr = addr_arr[idx];
                ptr_nxt      = (32'(idx) + 1 == N_REQ) ? '0 : idx + 1'b1;
            end
        end
    end

    // Arbiter pointer and credit counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            ptr <= ptr_nxt;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && !pop[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!grant[i] && pop[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Tag pipeline: follows each issued read to the cycle its data is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            for (int unsigned s = 0; s < STG; s++) tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= |grant;
            tag_id[0]  <= grant;
            for (int unsigned s = 1; s < STG; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

`ifdef SRAM_RD_REG_EN
    logic [DATA_W-1:0] rd_data_q;

    // Retime SRAM read data; the extra tag stage lines up with this register
    always_ff @(posedge clk) begin
        rd_data_q <= sram_rd_data;
    end

    assign wr_data = rd_data_q;
`else
    assign wr_data = sram_rd_data;
`endif

    assign push = tag_vld[STG-1] ? tag_id[STG-1] : '0;

    // Response FIFO pointers (extra MSB distinguishes full from empty)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // Response FIFO storage; contents need no reset since valid comes from pointers
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sram_read_dispatch.sv
// Self-checking bench for sram_read_dispatch: directed scenarios plus a random
// phase, all compared each cycle against a queue-based reference model.
module tb_sram_read_dispatch;

    localparam int N     = 3;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int QS    = 8;
`ifdef SRAM_RD_REG_EN
    localparam int RSP_LAT = LAT + 2;
`else
    localparam int RSP_LAT = LAT + 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic              sram_rd_en;
    logic [AW-1:0]     sram_rd_addr;
    logic [DW-1:0]     sram_rd_data;
    logic [N-1:0]      rsp_valid;
    logic [N*DW-1:0]   rsp_data;
    logic [N-1:0]      rsp_ready;
    logic              busy;

    logic [AW-1:0]     addr_a [N];
    logic [DW-1:0]     smem [1024];
    logic [DW-1:0]     sd [LAT];

    // reference model: per-requester circular queue of {data, ready cycle}
    logic [DW-1:0]     qd [N][QS];
    int                qt [N][QS];
    int                qh [N];
    int                qn [N];
    int                oc [N];
    int                cyc;
    int                ptr_m;

    int                checks = 0;
    int                errors = 0;

    logic [N-1:0]      s_ready, s_valid;
    logic              s_en;
    logic [AW-1:0]     s_addr;
    logic [N*DW-1:0]   s_data;
    int                acc0, g12;

    sram_read_dispatch #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_a[i];
    end

    // SRAM model: fixed read latency, junk data when not strobed
    always @(posedge clk) begin
        sd[0] <= sram_rd_en ? smem[sram_rd_addr] : DW'($urandom);
        for (int k = 1; k < LAT; k++) sd[k] <= sd[k-1];
    end
    assign sram_rd_data = sd[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_sram_rd_en"}, 64'(sram_rd_en), 64'd0);
        chk({tag, "_sram_rd_addr"}, 64'(sram_rd_addr), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) addr_a[i] = AW'($urandom);
    endtask

    // One clock cycle: check outputs at negedge, advance the model at posedge
    task automatic tick();
        logic [N-1:0]    eg, ev, epop;
        logic [AW-1:0]   ea;
        logic [N*DW-1:0] ed;
        logic            eb, found, ovf;
        int              j, k, slot;
        @(negedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                qn[i] = 0; qh[i] = 0; oc[i] = 0;
            end
            ptr_m = 0;
        end
        eg = '0; ea = '0; found = 1'b0; k = 0;
        if (!reset) begin
            for (int o = 0; o < N; o++) begin
                j = (ptr_m + o) % N;
                if (!found && req_valid[j] && qn[j] < DEPTH) begin
                    found = 1'b1; k = j; eg[j] = 1'b1; ea = addr_a[j];
                end
            end
        end
        ev = '0; ed = '0; eb = 1'b0;
        for (int i = 0; i < N; i++) begin
            ev[i] = (qn[i] > 0) && (qt[i][qh[i]] <= cyc);
            if (ev[i]) ed[i*DW +: DW] = qd[i][qh[i]];
            if (qn[i] > 0) eb = 1'b1;
        end
        s_ready = req_ready; s_valid = rsp_valid; s_en = sram_rd_en;
        s_addr = sram_rd_addr; s_data = rsp_data;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("sram_rd_en", 64'(sram_rd_en), 64'(|eg));
        chk("sram_rd_addr", 64'(sram_rd_addr), 64'(ea));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_data", 64'(rsp_data), 64'(ed));
        chk("busy", 64'(busy), 64'(eb));
        // credits seen at the ports must never exceed the FIFO depth
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            oc[i] = oc[i] + int'(req_valid[i] & req_ready[i]) - int'(rsp_valid[i] & rsp_ready[i]);
            if (oc[i] > DEPTH || oc[i] < 0) ovf = 1'b1;
        end
        chk("credit_bound", 64'(ovf), 64'd0);
        epop = ev & rsp_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (epop[i]) begin
                qh[i] = (qh[i] + 1) % QS;
                qn[i] = qn[i] - 1;
            end
        end
        if (found) begin
            slot = (qh[k] + qn[k]) % QS;
            qd[k][slot] = smem[ea];
            qt[k][slot] = cyc + RSP_LAT;
            qn[k] = qn[k] + 1;
            ptr_m = (k + 1) % N;
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0; qh[i] = 0; qn[i] = 0; oc[i] = 0;
        end
        for (int a = 0; a < 1024; a++) smem[a] = DW'($urandom);
        smem[5] = 16'hBEEF;
        cyc = 0; ptr_m = 0;

        // reset state, with requests pending
        #1 req_valid = '1;
        repeat (2) tick();
        check_zero("por");
        reset = 1'b0; req_valid = '0;
        repeat (2) tick();

        // single read: requester 1, address 0x05
        req_valid = 3'b010; addr_a[1] = 10'h005;
        tick();
        chk("sr_en", 64'(s_en), 64'd1);
        chk("sr_addr", 64'(s_addr), 64'h005);
        req_valid = '0;
        for (int d = 1; d <= RSP_LAT; d++) begin
            tick();
            chk("sr_valid", 64'(s_valid), (d == RSP_LAT) ? 64'b010 : 64'b000);
        end
        chk("sr_data", 64'(s_data[31:16]), 64'hBEEF);
        rsp_ready = 3'b010; tick();
        rsp_ready = '0; tick();

        // backpressure on requester 0
        req_valid = 3'b111; rsp_ready = 3'b110; acc0 = 0; g12 = 0;
        repeat (24) begin
            rand_addrs(); tick();
            acc0 += int'(s_ready[0]);
            g12  += int'(s_ready[1] | s_ready[2]);
        end
        chk("bp_accepts", 64'(acc0), 64'd4);
        chk("bp_others", 64'(g12), 64'd20);
        acc0 = 0;
        rsp_ready = 3'b111; rand_addrs(); tick();
        acc0 += int'(s_ready[0]);
        rsp_ready = 3'b110;
        repeat (12) begin
            rand_addrs(); tick();
            acc0 += int'(s_ready[0]);
        end
        chk("bp_after_pop", 64'(acc0), 64'd1);
        req_valid = '0; rsp_ready = '1;
        repeat (10) tick();

        // FIFO 2 at full credit, pop in the cycle the last read lands
        rsp_ready = '0; req_valid = 3'b100;
        repeat (3) begin rand_addrs(); tick(); end
        req_valid = '0;
        repeat (3) tick();
        req_valid = 3'b100; rand_addrs(); tick();
        chk("ff_last_grant", 64'(s_ready), 64'b100);
        rsp_ready = 3'b100; rand_addrs(); tick();
        chk("ff_full_block", 64'(s_ready), 64'b000);
        repeat (10) begin rand_addrs(); tick(); end
        req_valid = '0; rsp_ready = '1;
        repeat (10) tick();

        // reset in the cycle after a grant
        req_valid = 3'b001; rsp_ready = '0; rand_addrs();
        tick();
        req_valid = 3'b111; reset = 1'b1;
        #1 check_zero("mid");
        repeat (2) tick();
        reset = 1'b0; req_valid = '0;
        repeat (3) tick();
        chk("post_rst_valid", 64'(s_valid), 64'd0);

        // round robin from a freshly reset pointer
        req_valid = '1; rsp_ready = '1;
        for (int n = 0; n < 12; n++) begin
            rand_addrs(); tick();
            chk("rr_grant", 64'(s_ready), 64'(1 << (n % 3)));
        end

        // random traffic
        repeat (400) begin
            req_valid = N'($urandom); rsp_ready = N'($urandom); rand_addrs();
            tick();
        end
        req_valid = '0; rsp_ready = '1;
        repeat (10) tick();
        chk("final_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
